// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module  : register_file_pkg
// Purpose : Shared widths and types for the renaming architectural register file.
// Revision: 1.0
// ============================================================================
package register_file_pkg;

   localparam int REG_IDX_W = 5;
   localparam int DATA_W    = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0]    data_t;

   localparam reg_idx_t ZERO_REG = '0;
   localparam data_t    ZERO_DATA = '0;

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module  : regfile_read_port
// Purpose : Combinational source lookup with rename and commit bypass.
// Revision: 1.0
// ============================================================================
module regfile_read_port
   import register_file_pkg::*;
#(
   parameter int ROB_ID_W = 4
) (
   input  reg_idx_t            idx,
   input  logic [ROB_ID_W-1:0] tag,
   input  data_t               value,
   input  logic                rename_en,
   input  reg_idx_t            rename_rd,
   input  logic [ROB_ID_W-1:0] rename_alias,
   input  logic                commit_en,
   input  reg_idx_t            commit_rd,
   input  logic [ROB_ID_W-1:0] commit_alias,
   input  data_t               commit_value,
   output logic [ROB_ID_W-1:0] q,
   output data_t               v
);

   // A rename in flight makes this source depend on the new producer, even if
   // the old one is committing in the same cycle.
   always_comb begin
      q = '0;
      v = ZERO_DATA;
      if (idx == ZERO_REG) begin
         q = '0;
         v = ZERO_DATA;
      end else if (rename_en && (rename_rd == idx)) begin
         q = rename_alias;
         v = ZERO_DATA;
      end else if (commit_en && (commit_rd == idx) && (tag == commit_alias)) begin
         q = '0;
         v = commit_value;
      end else begin
         q = tag;
         v = value;
      end
   end

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module  : register_file
// Purpose : 32x32 architectural register file with ROB rename tags and bypass.
// Revision: 1.0
// ============================================================================
module register_file
   import register_file_pkg::*;
#(
   parameter int ROB_ID_W = 4,
   parameter int NUM_REGS = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                rollback_signal,
   input  logic                ena_regfile_rename,
   input  reg_idx_t            rd_2reg,
   input  logic [ROB_ID_W-1:0] rd_alias,
   input  reg_idx_t            rs1_2reg,
   input  reg_idx_t            rs2_2reg,
   output logic [ROB_ID_W-1:0] Qi_from_rg,
   output logic [ROB_ID_W-1:0] Qj_from_rg,
   output data_t               Vi_from_rg,
   output data_t               Vj_from_rg,
   input  logic                commit_en,
   input  reg_idx_t            commit_rd,
   input  logic [ROB_ID_W-1:0] commit_alias,
   input  data_t               commit_value
);

   data_t               w_values [NUM_REGS];
   logic [ROB_ID_W-1:0] w_tags   [NUM_REGS];

   assign w_values[0] = ZERO_DATA;
   assign w_tags[0]   = '0;

   generate
      for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_regs
         localparam reg_idx_t c_idx = REG_IDX_W'(gi);
         data_t               r_value;
         logic [ROB_ID_W-1:0] r_tag;

         // Rollback clears the tag and beats a same-cycle rename; rename beats
         // the commit's tag clear because the younger producer owns the register.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_value <= ZERO_DATA;
               r_tag   <= '0;
            end else if (rdy) begin
               if (commit_en && (commit_rd == c_idx)) begin
                  r_value <= commit_value;
                  if (r_tag == commit_alias) begin
                     r_tag <= '0;
                  end
               end
               if (rollback_signal) begin
                  r_tag <= '0;
               end else if (ena_regfile_rename && (rd_2reg == c_idx)) begin
                  r_tag <= rd_alias;
               end
            end
         end

         assign w_values[gi] = r_value;
         assign w_tags[gi]   = r_tag;
      end
   endgenerate

   regfile_read_port #(.ROB_ID_W(ROB_ID_W)) u_port_rs1 (
      .idx          (rs1_2reg),
      .tag          (w_tags[rs1_2reg]),
      .value        (w_values[rs1_2reg]),
      .rename_en    (ena_regfile_rename),
      .rename_rd    (rd_2reg),
      .rename_alias (rd_alias),
      .commit_en    (commit_en),
      .commit_rd    (commit_rd),
      .commit_alias (commit_alias),
      .commit_value (commit_value),
      .q            (Qi_from_rg),
      .v            (Vi_from_rg)
   );

   regfile_read_port #(.ROB_ID_W(ROB_ID_W)) u_port_rs2 (
      .idx          (rs2_2reg),
      .tag          (w_tags[rs2_2reg]),
      .value        (w_values[rs2_2reg]),
      .rename_en    (ena_regfile_rename),
      .rename_rd    (rd_2reg),
      .rename_alias (rd_alias),
      .commit_en    (commit_en),
      .commit_rd    (commit_rd),
      .commit_alias (commit_alias),
      .commit_value (commit_value),
      .q            (Qj_from_rg),
      .v            (Vj_from_rg)
   );

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module  : tb_register_file
// Purpose : Directed and randomized self-checking bench for register_file.
// Revision: 1.0
// ============================================================================
module tb_register_file;

   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst, rdy, rollback_signal, ena_regfile_rename, commit_en;
   logic [4:0]    rd_2reg, rs1_2reg, rs2_2reg, commit_rd;
   logic [RW-1:0] rd_alias, commit_alias, Qi_from_rg, Qj_from_rg;
   logic [31:0]   Vi_from_rg, Vj_from_rg, commit_value;

   int errors = 0;
   int checks = 0;

   // Architectural state as the specification describes it.
   logic [31:0]   mv [32];
   logic [RW-1:0] mt [32];

   register_file #(.ROB_ID_W(RW), .NUM_REGS(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .rdy                (rdy),
      .rollback_signal    (rollback_signal),
      .ena_regfile_rename (ena_regfile_rename),
      .rd_2reg            (rd_2reg),
      .rd_alias           (rd_alias),
      .rs1_2reg           (rs1_2reg),
      .rs2_2reg           (rs2_2reg),
      .Qi_from_rg         (Qi_from_rg),
      .Qj_from_rg         (Qj_from_rg),
      .Vi_from_rg         (Vi_from_rg),
      .Vj_from_rg         (Vj_from_rg),
      .commit_en          (commit_en),
      .commit_rd          (commit_rd),
      .commit_alias       (commit_alias),
      .commit_value       (commit_value)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         mv[i] = '0;
         mt[i] = '0;
      end
   endfunction

   function automatic void model_apply();
      logic [RW-1:0] old_tag;
      if (commit_en && commit_rd != 0) begin
         old_tag = mt[commit_rd];
         mv[commit_rd] = commit_value;
         if (old_tag == commit_alias) mt[commit_rd] = '0;
      end
      if (rollback_signal) begin
         for (int i = 0; i < 32; i++) mt[i] = '0;
      end else if (ena_regfile_rename && rd_2reg != 0) begin
         mt[rd_2reg] = rd_alias;
      end
   endfunction

   function automatic void model_read(input logic [4:0] idx,
                                      output logic [RW-1:0] q, output logic [31:0] v);
      if (idx == 0) begin
         q = '0; v = '0;
      end else if (ena_regfile_rename && rd_2reg == idx) begin
         q = rd_alias; v = '0;
      end else if (commit_en && commit_rd == idx && mt[idx] == commit_alias) begin
         q = '0; v = commit_value;
      end else begin
         q = mt[idx]; v = mv[idx];
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rst && rdy) model_apply();
      #1;
   endtask

   task automatic idle();
      rdy = 1'b1; rollback_signal = 1'b0; ena_regfile_rename = 1'b0; commit_en = 1'b0;
      rd_2reg = '0; rd_alias = '0; commit_rd = '0; commit_alias = '0; commit_value = '0;
   endtask

   task automatic rename(input logic [4:0] rd, input logic [RW-1:0] al);
      ena_regfile_rename = 1'b1; rd_2reg = rd; rd_alias = al;
   endtask

   task automatic commit(input logic [4:0] rd, input logic [RW-1:0] al, input logic [31:0] val);
      commit_en = 1'b1; commit_rd = rd; commit_alias = al; commit_value = val;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1; rs1_2reg = 5'd5; rs2_2reg = 5'd0;
      model_reset();
      #2;
      checks++;
      if ({Qi_from_rg, Vi_from_rg} !== {4'd0, 32'd0}) begin
         errors++; $display("FAIL reset_rs1: got Q=%0d V=%h want Q=0 V=0", Qi_from_rg, Vi_from_rg);
      end
      checks++;
      if ({Qj_from_rg, Vj_from_rg} !== {4'd0, 32'd0}) begin
         errors++; $display("FAIL reset_x0: got Q=%0d V=%h want Q=0 V=0", Qj_from_rg, Vj_from_rg);
      end
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_rename_commit();
      idle(); rename(5'd5, 4'd3); rs1_2reg = 5'd5;
      tick();
      idle(); #1;
      checks++;
      if ({Qi_from_rg, Vi_from_rg} !== {4'd3, 32'd0}) begin
         errors++; $display("FAIL rc_tag: got Q=%0d V=%h want Q=3 V=0", Qi_from_rg, Vi_from_rg);
      end
      commit(5'd5, 4'd3, 32'h1234); #1;
      checks++;
      if ({Qi_from_rg, Vi_from_rg} !== {4'd0, 32'h1234}) begin
         errors++; $display("FAIL rc_commit_bypass: got Q=%0d V=%h want Q=0 V=1234", Qi_from_rg, Vi_from_rg);
      end
      tick();
      idle(); #1;
      checks++;
      if ({Qi_from_rg, Vi_from_rg} !== {4'd0, 32'h1234}) begin
         errors++; $display("FAIL rc_state: got Q=%0d V=%h want Q=0 V=1234", Qi_from_rg, Vi_from_rg);
      end
   endtask

   task automatic test_stale_commit();
      idle(); rename(5'd5, 4'd3); tick();
      idle(); rename(5'd5, 4'd7); tick();
      idle(); commit(5'd5, 4'd3, 32'hAA); rs1_2reg = 5'd5; #1;
      checks++;
      if ({Qi_from_rg, Vi_from_rg} !== {4'd7, 32'h1234}) begin
         errors++; $display("FAIL stale_bypass: got Q=%0d V=%h want Q=7 V=1234", Qi_from_rg, Vi_from_rg);
      end
      tick();
      idle(); #1;
      checks++;
      if ({Qi_from_rg, Vi_from_rg} !== {4'd7, 32'hAA}) begin
         errors++; $display("FAIL stale_state: got Q=%0d V=%h want Q=7 V=aa", Qi_from_rg, Vi_from_rg);
      end
   endtask

   task automatic test_rename_bypass();
      idle(); rename(5'd8, 4'd4); rs2_2reg = 5'd8; #2;
      checks++;
      if ({Qj_from_rg, Vj_from_rg} !== {4'd4, 32'd0}) begin
         errors++; $display("FAIL rename_bypass: got Q=%0d V=%h want Q=4 V=0", Qj_from_rg, Vj_from_rg);
      end
      tick();
      idle();
   endtask

   task automatic test_rollback();
      logic [RW-1:0] al [4];
      al[1] = 4'd1; al[2] = 4'd2; al[3] = 4'd5;
      for (int i = 1; i <= 3; i++) begin
         idle(); rename(5'(i), al[i]); tick();
      end
      idle();
      rollback_signal = 1'b1; commit(5'd2, 4'd2, 32'd9); rename(5'd4, 4'd6);
      tick();
      idle();
      for (int i = 1; i <= 4; i++) begin
         rs1_2reg = 5'(i); #1;
         checks++;
         if (Qi_from_rg !== 4'd0) begin
            errors++; $display("FAIL rollback_tag x%0d: got Q=%0d want Q=0", i, Qi_from_rg);
         end
      end
      rs2_2reg = 5'd2; #1;
      checks++;
      if (Vj_from_rg !== 32'd9) begin
         errors++; $display("FAIL rollback_value: got V=%h want V=9", Vj_from_rg);
      end
   endtask

   task automatic test_pause_x0();
      idle(); rdy = 1'b0; commit(5'd6, 4'd1, 32'h55); rs1_2reg = 5'd6;
      tick();
      idle(); #1;
      checks++;
      if ({Qi_from_rg, Vi_from_rg} !== {4'd0, 32'd0}) begin
         errors++; $display("FAIL pause_hold: got Q=%0d V=%h want Q=0 V=0", Qi_from_rg, Vi_from_rg);
      end
      rename(5'd0, 4'd2); rs1_2reg = 5'd0; #1;
      checks++;
      if ({Qi_from_rg, Vi_from_rg} !== {4'd0, 32'd0}) begin
         errors++; $display("FAIL x0_bypass: got Q=%0d V=%h want Q=0 V=0", Qi_from_rg, Vi_from_rg);
      end
      tick();
      idle(); #1;
      checks++;
      if ({Qi_from_rg, Vi_from_rg} !== {4'd0, 32'd0}) begin
         errors++; $display("FAIL x0_state: got Q=%0d V=%h want Q=0 V=0", Qi_from_rg, Vi_from_rg);
      end
   endtask

   task automatic test_random();
      logic [RW-1:0] eq;
      logic [31:0]   ev;
      for (int n = 0; n < 400; n++) begin
         rdy                = ($urandom_range(0, 9) != 0);
         rollback_signal    = ($urandom_range(0, 19) == 0);
         ena_regfile_rename = $urandom_range(0, 1) == 1;
         rd_2reg            = 5'($urandom_range(0, 7));
         rd_alias           = RW'($urandom_range(1, 15));
         commit_en          = $urandom_range(0, 1) == 1;
         commit_rd          = 5'($urandom_range(0, 7));
         commit_alias       = $urandom_range(0, 2) != 0 ? mt[commit_rd] : RW'($urandom_range(1, 15));
         commit_value       = $urandom;
         rs1_2reg           = 5'($urandom_range(0, 7));
         rs2_2reg           = $urandom_range(0, 1) == 1 ? rd_2reg : commit_rd;
         #2;
         model_read(rs1_2reg, eq, ev);
         checks++;
         if ({Qi_from_rg, Vi_from_rg} !== {eq, ev}) begin
            errors++; $display("FAIL rand_rs1 n=%0d x%0d: got Q=%0d V=%h want Q=%0d V=%h",
                               n, rs1_2reg, Qi_from_rg, Vi_from_rg, eq, ev);
         end
         model_read(rs2_2reg, eq, ev);
         checks++;
         if ({Qj_from_rg, Vj_from_rg} !== {eq, ev}) begin
            errors++; $display("FAIL rand_rs2 n=%0d x%0d: got Q=%0d V=%h want Q=%0d V=%h",
                               n, rs2_2reg, Qj_from_rg, Vj_from_rg, eq, ev);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      rs1_2reg = '0; rs2_2reg = '0;
      test_reset();
      test_rename_commit();
      test_stale_commit();
      test_rename_bypass();
      test_rollback();
      test_pause_x0();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with rename tags for the out-of-order core: 32 x 32-bit values, each with a ROB-alias tag.
- Responder side of the dispatcher's issue interface:
  - accepts rename requests (rd -> ROB alias);
  - answers the two combinational source lookups (rs1/rs2 -> Q/V);
  - retires values on ROB commit;
  - clears all tags on rollback.

Parameters:
- ROB_ID_W, 4, width of ROB alias; alias 0 (`RENAMED_ZERO) means "no pending producer"
- NUM_REGS, 32, architectural registers; x0 hardwired

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global ready; low = pause all state updates
- rollback_signal  in  1  misprediction flush from ROB
- ena_regfile_rename  in  1  rename request valid (registered output of dispatcher)
- rd_2reg  in  5  destination register to rename
- rd_alias  in  ROB_ID_W  ROB alias assigned to rd
- rs1_2reg  in  5  source 1 index
- rs2_2reg  in  5  source 2 index
- Qi_from_rg  out  ROB_ID_W  rs1 pending alias, 0 if value ready
- Qj_from_rg  out  ROB_ID_W  rs2 pending alias
- Vi_from_rg  out  32  rs1 value (valid when Qi_from_rg==0)
- Vj_from_rg  out  32  rs2 value
- commit_en  in  1  ROB commits an instruction writing a register
- commit_rd  in  5  committed destination
- commit_alias  in  ROB_ID_W  ROB alias of committed instruction
- commit_value  in  32  committed result

Behaviour:
- Reset (async, rst=1): all values = 0, all tags = 0; read outputs therefore show Q=0, V=0.
- State per register: value[31:0], tag[ROB_ID_W-1:0]. x0: value and tag permanently 0; writes and renames to x0 are ignored.
- Updates occur at posedge clk only when rst=0 and rdy=1; rdy=0 holds all state and leaves reads combinational.
- Commit, at posedge when commit_en and commit_rd!=0:
  - value[commit_rd] <= commit_value.
  - tag[commit_rd] <= 0 only if tag==commit_alias; otherwise the tag is kept, because a younger rename owns the register.
- Rename, at posedge when ena_regfile_rename, rd_2reg!=0 and no rollback: tag[rd_2reg] <= rd_alias.
- Same cycle, same register, commit and rename: value takes commit_value; tag takes rd_alias (rename wins).
- Rollback, at posedge when rollback_signal:
  - commit is still applied to value;
  - every tag <= 0;
  - rename in the same cycle is dropped.
- Read ports are combinational, zero latency, with bypass priority per port (rs1 shown; rs2 identical):
  1. rs1==0 -> Q=0, V=0.
  2. ena_regfile_rename && rd_2reg==rs1 -> Q=rd_alias, V=0. This is required because the dispatcher's rename lands one cycle after issue.
  3. commit_en && commit_rd==rs1 && tag[rs1]==commit_alias -> Q=0, V=commit_value.
  4. Otherwise Q=tag[rs1], V=value[rs1].
- Bypasses are gated by neither rdy nor rollback. The dispatcher discards its issue on rollback.
- Alias wrap-around: tag comparison is pure equality. The ROB guarantees that aliases are unique among in-flight instructions.

Decomposition:
- Shared const.v supplies `REG_RANGE, `ROB_ID_RANGE, `DATA_IDX_RANGE, `RENAMED_ZERO, `ZERO, `TRUE/`FALSE. No new package items.
- One natural sub-module, regfile_read_port, instantiated twice. It implements the 4-level bypass mux from: index, tag, value, rename bus and commit bus.

Test Plan:
- Reset then read: assert rst -> Qi=0, Vi=0 for rs1=5; also read rs1=0 -> 0/0.
- Rename then commit:
  - rename x5 -> alias 3 on cycle 1;
  - cycle 2: rs1=5 -> Qi=3;
  - commit x5 alias 3 value 0x1234 -> same-cycle Qi=0, Vi=0x1234, and state tag 0 afterward.
- Stale commit: rename x5->3, then rename x5->7, then commit x5 alias 3 value 0xAA:
  - value becomes 0xAA, tag stays 7;
  - a read in the commit cycle returns Qi=7.
- Rename bypass: ena_regfile_rename with x8->4 and rs2=8 in the same cycle -> Qj=4 combinationally before the clock edge.
- Rollback: tags set on x1..x3 (aliases 1,2,5), then rollback with concurrent commit x2 alias 2 value 9 and rename x4->6:
  - all tags 0;
  - x2 value 9;
  - x4 tag 0.
- Pause and x0:
  - rdy=0 with commit x6 value 0x55 -> x6 unchanged after the edge;
  - rename x0->2 with rdy=1 -> reading x0 returns 0/0.
